rr_stream_mux: RTL and testbench

Parametrised N-channel, W-bit stream multiplexer with a valid/ready handshake, packet locking and a registered output. It is the successor to the team's combinational 1-bit 4:1 selector. It sits between several producer streams and one consumer. The channel is chosen either by an external select (fixed mode) or by round-robin arbitration. Once a channel is granted, it keeps the output until its packet's last beat has been accepted.

---
 rtl/rr_mux_pkg.sv | 37 +++
 rtl/rr_arbiter.sv | 21 ++
 rtl/rr_stream_mux.sv | 124 ++++++++++++
 tb/tb_rr_stream_mux.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared state encoding and round-robin search for rr_stream_mux
package rr_mux_pkg;

    localparam int MAX_CH = 32;
    // One spare index bit so every legal SW leaves a non-empty remainder to discard.
    localparam int IDX_W  = 6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } mux_state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First requester strictly after `last`, wrapping at n-1 -> 0.
    function automatic rr_pick_t rr_next(input logic [MAX_CH-1:0] req,
                                         input int last,
                                         input int n);
        rr_pick_t pick;
        int       c;
        pick = '0;
        for (int k = 1; k <= MAX_CH; k++) begin
            if (k <= n) begin
                c = (last + k) % n;
                if (!pick.found && req[c[IDX_W-2:0]]) begin
                    pick.found = 1'b1;
                    pick.idx   = c[IDX_W-1:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotating-priority pick for rr_stream_mux
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int SW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [SW-1:0]   last,
    output logic [SW-1:0]   gnt_idx,
    output logic            gnt_found
);

    rr_pick_t            w_pick;
    logic [IDX_W-SW-1:0] w_idx_unused;

    assign w_pick = rr_next(MAX_CH'(req), int'(last), N_CH);
    assign {w_idx_unused, gnt_idx} = w_pick.idx;
    assign gnt_found = w_pick.found;

endmodule

// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - N-channel packet-locking stream mux with registered output
module rr_stream_mux
    import rr_mux_pkg::*;
#(
    parameter  int N_CH    = 4,
    parameter  int WIDTH   = 8,
    parameter  int RR_MODE = 1,
    localparam int SW      = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH-1:0]       in_last,
    output logic [N_CH-1:0]       in_ready,
    input  logic [SW-1:0]         sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [SW-1:0]         out_ch
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_LOCK = LOCK;

    logic [0:0]       r_state;
    logic [SW-1:0]    r_gnt;
    logic [SW-1:0]    r_last;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_last;
    logic [SW-1:0]    r_out_ch;

    logic [SW-1:0]    w_pick_idx;
    logic             w_pick_found;
    logic [N_CH-1:0]  w_gnt_onehot;
    logic             w_out_free;
    logic [N_CH-1:0]  w_in_ready;
    logic             w_xfer;
    logic             w_gnt_last;
    logic [WIDTH-1:0] w_gnt_data;

    generate
        if (RR_MODE != 0) begin : g_rr
            logic w_sel_unused;
            assign w_sel_unused = ^sel;

            rr_arbiter #(.N_CH(N_CH)) u_arb (
                .req       (in_valid),
                .last      (r_last),
                .gnt_idx   (w_pick_idx),
                .gnt_found (w_pick_found)
            );
        end else begin : g_fixed
            logic            w_last_unused;
            logic [N_CH-1:0] w_sel_onehot;
            assign w_last_unused = ^r_last;
            assign w_sel_onehot  = N_CH'(1) << sel;
            assign w_pick_idx    = sel;
            assign w_pick_found  = (int'(sel) < N_CH) && |(in_valid & w_sel_onehot);
        end
    endgenerate

    assign w_gnt_onehot = N_CH'(1) << r_gnt;
    // The output register can take a beat when empty or being drained this cycle.
    assign w_out_free   = !r_out_valid || out_ready;
    assign w_in_ready   = (r_state == ST_LOCK && w_out_free) ? w_gnt_onehot : '0;
    assign w_xfer       = |(in_valid & w_in_ready);
    assign w_gnt_last   = |(in_last & w_gnt_onehot);

    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_gnt_onehot[i]) begin
                w_gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_last      <= SW'(N_CH - 1);
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_ch    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_found) begin
                        r_state <= ST_LOCK;
                        r_gnt   <= w_pick_idx;
                    end
                end
                ST_LOCK: begin
                    if (w_xfer && w_gnt_last) begin
                        r_state <= ST_IDLE;
                        r_last  <= r_gnt;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_xfer) begin
                r_out_data  <= w_gnt_data;
                r_out_last  <= w_gnt_last;
                r_out_ch    <= r_gnt;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb/tb_rr_stream_mux.sv - scoreboard bench for rr_stream_mux (round-robin and fixed select)
module tb_rr_stream_mux;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           out_ready;
    logic [1:0]     sel;
    logic           use_fixed;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;

    logic [N-1:0] rdy_r, rdy_f, cur_ready;
    logic [W-1:0] dat_r, dat_f, cur_data;
    logic         vld_r, vld_f, cur_valid;
    logic         lst_r, lst_f, cur_last;
    logic [1:0]   ch_r, ch_f, cur_ch;

    rr_stream_mux #(.N_CH(N), .WIDTH(W), .RR_MODE(1)) u_dut_rr (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(rdy_r), .sel(sel), .out_data(dat_r),
        .out_valid(vld_r), .out_last(lst_r), .out_ready(out_ready), .out_ch(ch_r)
    );

    rr_stream_mux #(.N_CH(N), .WIDTH(W), .RR_MODE(0)) u_dut_fx (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(rdy_f), .sel(sel), .out_data(dat_f),
        .out_valid(vld_f), .out_last(lst_f), .out_ready(out_ready), .out_ch(ch_f)
    );

    assign cur_ready = use_fixed ? rdy_f : rdy_r;
    assign cur_data  = use_fixed ? dat_f : dat_r;
    assign cur_valid = use_fixed ? vld_f : vld_r;
    assign cur_last  = use_fixed ? lst_f : lst_r;
    assign cur_ch    = use_fixed ? ch_f  : ch_r;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int hs_cnt   = 0;
    int hs_cyc[$];
    logic [10:0] exp_q[$];

    logic [8:0]   pm [N][32];
    int           ph [N] = '{default: 0};
    int           pt [N] = '{default: 0};
    logic [N-1:0] fire;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int ch, input logic [7:0] d, input logic l);
        pm[ch][pt[ch]] = {l, d};
        pt[ch]++;
    endtask

    task automatic expect_beat(input int ch, input logic [7:0] d, input logic l);
        exp_q.push_back({2'(ch), l, d});
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += pt[i] - ph[i];
        return s;
    endfunction

    task automatic wait_drain(input int budget);
        int n = 0;
        while (n < budget && (exp_q.size() != 0 || pending() != 0)) begin
            tick();
            n++;
        end
        check("drain_expected", exp_q.size(), 0);
        check("drain_producers", pending(), 0);
    endtask

    // Producers: present queue heads, pop on a handshake seen before the edge.
    initial begin
        in_valid = '0;
        in_last  = '0;
        in_data  = '0;
        forever begin
            @(negedge clk);
            fire = rst ? '0 : (in_valid & cur_ready);
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (fire[i]) ph[i]++;
                if (ph[i] < pt[i]) begin
                    in_valid[i]        = 1'b1;
                    in_last[i]         = pm[i][ph[i]][8];
                    in_data[i*W +: W]  = pm[i][ph[i]][7:0];
                end else begin
                    in_valid[i]        = 1'b0;
                    in_last[i]         = 1'b0;
                    in_data[i*W +: W]  = '0;
                end
            end
        end
    end

    // Monitor: every output handshake pops and compares one expected beat.
    initial forever begin
        @(negedge clk);
        if (!rst && cur_valid && out_ready) begin
            hs_cnt++;
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("spurious_beat", {21'b0, cur_ch, cur_last, cur_data}, 32'hFFFF_FFFF);
            end else begin
                check("beat", {21'b0, cur_ch, cur_last, cur_data}, {21'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1; out_ready = 1'b1; sel = 2'd0; use_fixed = 1'b0;

        // Reset with every channel requesting, then two round-robin rounds of 1-beat packets.
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < N; c++) begin
                push(c, 8'((r == 0 ? 8'h10 : 8'h20) + c), 1'b1);
                expect_beat(c, 8'((r == 0 ? 8'h10 : 8'h20) + c), 1'b1);
            end
        tick(); tick();
        @(negedge clk);
        check("rst_out_valid", cur_valid, 0);
        check("rst_in_ready", cur_ready, 0);
        check("rst_out_ch", cur_ch, 0);
        check("rst_out_data", cur_data, 0);
        tick();
        rst = 1'b0;
        hs_cyc.delete();
        @(negedge clk);
        check("arb_cycle_ready", cur_ready, 4'b0000);
        @(negedge clk);
        check("first_grant_ready", cur_ready, 4'b0001);
        wait_drain(200);
        check("rr_beat_count", hs_cyc.size(), 8);
        if (hs_cyc.size() >= 8)
            for (int k = 0; k < 7; k++) check("rr_bubble_gap", hs_cyc[k+1] - hs_cyc[k], 2);

        // Packet lock: ch2 holds the stream while ch0/ch1/ch3 wait; ch3 follows.
        push(1, 8'h31, 1'b1); expect_beat(1, 8'h31, 1'b1);
        wait_drain(50);
        push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1);
        push(0, 8'h40, 1'b1); push(1, 8'h41, 1'b1); push(3, 8'h43, 1'b1);
        expect_beat(2, 8'hA1, 1'b0); expect_beat(2, 8'hA2, 1'b0); expect_beat(2, 8'hA3, 1'b1);
        expect_beat(3, 8'h43, 1'b1); expect_beat(0, 8'h40, 1'b1); expect_beat(1, 8'h41, 1'b1);
        wait_drain(100);

        // Backpressure mid-packet: B1 must be held for 5 cycles.
        base = hs_cnt;
        for (int i = 0; i < 4; i++) begin
            push(0, 8'(8'hB0 + i), i == 3);
            expect_beat(0, 8'(8'hB0 + i), i == 3);
        end
        for (int n = 0; n < 50 && hs_cnt < base + 1; n++) tick();
        check("bp_first_beat_seen", hs_cnt - base, 1);
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("bp_hold_data", cur_data, 8'hB1);
            check("bp_hold_valid", cur_valid, 1);
            check("bp_in_ready", cur_ready, 0);
        end
        tick();
        out_ready = 1'b1;
        wait_drain(100);

        // Fixed select: sel moves to 3 after ch1's first beat; ch1 keeps the lock.
        use_fixed = 1'b1; sel = 2'd1; rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        push(3, 8'hD1, 1'b1);
        push(1, 8'hC1, 1'b0); push(1, 8'hC2, 1'b1);
        expect_beat(1, 8'hC1, 1'b0); expect_beat(1, 8'hC2, 1'b1); expect_beat(3, 8'hD1, 1'b1);
        base = ph[1];
        for (int n = 0; n < 50 && ph[1] < base + 1; n++) tick();
        check("fx_first_accept", ph[1] - base, 1);
        sel = 2'd3;
        wait_drain(100);

        // Reset during a ch1 packet: held beat dropped, ch0 wins afterwards.
        use_fixed = 1'b0; sel = 2'd0; rst = 1'b1;
        tick(); tick();
        rst = 1'b0; out_ready = 1'b0;
        tick();
        push(1, 8'hE1, 1'b0); push(1, 8'hE2, 1'b0); push(1, 8'hE3, 1'b1);
        base = ph[1];
        for (int n = 0; n < 50 && ph[1] < base + 1; n++) tick();
        check("mid_first_accept", ph[1] - base, 1);
        rst = 1'b1;
        ph[1] = pt[1];
        push(0, 8'hF0, 1'b1); push(1, 8'h61, 1'b1);
        expect_beat(0, 8'hF0, 1'b1); expect_beat(1, 8'h61, 1'b1);
        tick();
        @(negedge clk);
        check("mid_rst_out_valid", cur_valid, 0);
        check("mid_rst_in_ready", cur_ready, 0);
        tick();
        rst = 1'b0; out_ready = 1'b1;
        wait_drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
